// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: colour in, counters, strobes,
// registered sync/data-enable and blanked colour out.
interface vga_timing_gen_if #(
   parameter int XW = 10,
   parameter int YW = 10,
   parameter int DW = 3
);
   logic [DW-1:0] rgb_in;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          req_active;
   logic          pix_tick;
   logic          frame_start;
   logic          hsync;
   logic          vsync;
   logic          de;
   logic [DW-1:0] rgb_out;

   modport master (
      input  rgb_in,
      output x, y, req_active, pix_tick, frame_start, hsync, vsync, de, rgb_out
   );

   modport slave (
      output rgb_in,
      input  x, y, req_active, pix_tick, frame_start, hsync, vsync, de, rgb_out
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock prescaler, X/Y raster counters and a registered
// sync / data-enable / blanked-colour output stage updated once per pixel.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned CLK_DIV  = 1,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned CW       = 1,
   parameter int unsigned NCH      = 3
) (
   input logic               clk,
   input logic               rst,
   vga_timing_gen_if.master  vif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int          XW      = $clog2(H_TOTAL);
   localparam int          YW      = $clog2(V_TOTAL);
   localparam int          DW      = NCH * CW;
   // A divide-by-one prescaler still needs one bit to exist; it then stays at 0.
   localparam int          PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);

   logic [PW-1:0] pre;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          tick;
   logic          active;
   logic          hs_win;
   logic          vs_win;
   logic          hs_q;
   logic          vs_q;
   logic          de_q;
   logic [DW-1:0] rgb_q;

   assign tick   = ~rst & (pre == PRE_LAST);
   assign active = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
   // Window compares are done at 32 bits so a zero back porch cannot overflow XW/YW.
   assign hs_win = (32'(x_q) >= H_ACTIVE + H_FP) && (32'(x_q) < H_ACTIVE + H_FP + H_SYNC);
   assign vs_win = (32'(y_q) >= V_ACTIVE + V_FP) && (32'(y_q) < V_ACTIVE + V_FP + V_SYNC);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else if (tick) begin
         if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
         end else begin
            x_q <= x_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q  <= ~H_POL;
         vs_q  <= ~V_POL;
         de_q  <= 1'b0;
         rgb_q <= '0;
      end else if (tick) begin
         hs_q  <= hs_win ? H_POL : ~H_POL;
         vs_q  <= vs_win ? V_POL : ~V_POL;
         de_q  <= active;
         rgb_q <= active ? vif.rgb_in : '0;
      end
   end

   assign vif.x           = x_q;
   assign vif.y           = y_q;
   assign vif.req_active  = active;
   assign vif.pix_tick    = tick;
   assign vif.frame_start = tick && (x_q == '0) && (y_q == '0);
   assign vif.hsync       = hs_q;
   assign vif.vsync       = vs_q;
   assign vif.de          = de_q;
   assign vif.rgb_out     = rgb_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync pulse pixels.
REQ-004 Parameter H_BP, default 48: horizontal back-porch pixels.
REQ-005 Parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33: vertical equivalents, in lines.
REQ-006 Parameter CLK_DIV, default 1: CLK cycles per pixel; legal range 1..16.
REQ-007 Parameter H_POL, default 0: HSYNC asserted level. Parameter V_POL, default 0: VSYNC asserted level.
REQ-008 Parameter CW, default 1: bits per colour channel. Parameter NCH, default 3: number of colour channels.
REQ-009 CLK  input  1  system clock; all logic on rising edge.
REQ-010 RST  input  1  synchronous, active-high reset.
REQ-011 RGB_IN  input  NCH*CW  pixel colour for the current X/Y; channel 0 in the LSBs.
REQ-012 X  output  clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)  current horizontal count.
REQ-013 Y  output  clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)  current vertical count.
REQ-014 REQ_ACTIVE  output  1  high when X<H_ACTIVE and Y<V_ACTIVE.
REQ-015 PIX_TICK  output  1  one-CLK strobe marking the last CLK cycle of each pixel.
REQ-016 FRAME_START  output  1  one-CLK pulse on the PIX_TICK where X=0 and Y=0.
REQ-017 HSYNC, VSYNC, DE  output  1 each  registered sync and data-enable.
REQ-018 RGB_OUT  output  NCH*CW  registered, blanked colour.

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; counters SHALL be sized from these totals.
REQ-020 Prescaler SHALL count 0..CLK_DIV-1; PIX_TICK high when prescaler = CLK_DIV-1; CLK_DIV=1 gives PIX_TICK high every cycle.
REQ-021 On PIX_TICK, X SHALL increment; at X=H_TOTAL-1 X SHALL wrap to 0 and Y SHALL increment.
REQ-022 At X=H_TOTAL-1 and Y=V_TOTAL-1 on PIX_TICK, both SHALL wrap to 0 on the same edge.
REQ-023 X, Y, REQ_ACTIVE SHALL change only on the edge following a PIX_TICK.
REQ-024 RGB_IN SHALL be sampled only on the PIX_TICK cycle.
REQ-025 On PIX_TICK, the output stage SHALL register:
- HSYNC = H_POL when H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC, else ~H_POL
- VSYNC = V_POL when V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC, else ~V_POL
- DE = REQ_ACTIVE
- RGB_OUT = RGB_IN when REQ_ACTIVE, else 0
REQ-026 Output-stage latency SHALL be exactly one CLK after the PIX_TICK cycle; outputs hold between ticks.
REQ-027 VSYNC SHALL be evaluated on the full line count, so it changes at the X=0 pixel of the affected line.
REQ-028 FRAME_START SHALL be combinational from the prescaler and counters, with no added latency.
REQ-029 No parameter combination SHALL require a pixel clock other than CLK divided by CLK_DIV.

Reset
REQ-030 RST high at a rising edge SHALL clear the prescaler, X and Y to 0 on that edge.
REQ-031 The same edge SHALL drive HSYNC to ~H_POL, VSYNC to ~V_POL, DE to 0 and RGB_OUT to 0.
REQ-032 RST mid-line or mid-frame SHALL abort the frame.
REQ-033 The first PIX_TICK after RST release SHALL occur CLK_DIV cycles later and SHALL assert FRAME_START.
REQ-034 RST held high SHALL keep all outputs at reset values and PIX_TICK low.

Verification (small config: H 4/1/2/1, total 8; V 3/1/1/1, total 6; CLK_DIV=2; polarities 0; CW=1; NCH=3)
REQ-035 Release RST, hold RGB_IN=3'b101 -> PIX_TICK every 2nd CLK; FRAME_START every 96 CLK; DE high for pixels X=0..3 on lines Y=0..2; RGB_OUT=3'b101 only while DE=1.
REQ-036 Sync timing -> HSYNC low for pixels X=5..6 of every line, 4 CLK wide; VSYNC low for all of line Y=4, 16 CLK wide.
REQ-037 Registered output delay -> HSYNC falls 1 CLK after the PIX_TICK with X=5.
REQ-038 Change RGB_IN on a non-tick cycle -> RGB_OUT unaffected until the next PIX_TICK plus 1 CLK.
REQ-039 Assert RST at X=6, Y=4 for 1 CLK -> next edge X=0, Y=0, HSYNC=1, VSYNC=1, DE=0, RGB_OUT=0; FRAME_START 2 CLK after release.
REQ-040 Rebuild with CLK_DIV=1 and H_POL=V_POL=1 -> PIX_TICK constantly high; syncs high-true; frame period 48 CLK.
